// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU, debug and memory-side signal bundle for the data-memory arbiter
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [3:0]        dbg_wstrb;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: CPU-priority data-memory arbiter with debug starvation guard and read-return routing
// Optional out-of-range access check enabled by defining DMEM_ARB_BOUND_CHECK_EN.
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif
module dmem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WAIT  = 8,
  parameter int MEM_BYTES = `DATA_MEM_SIZE
) (
  input logic clk,
  input logic rst,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("MAX_WAIT out of range");
  end
  if (MEM_BYTES > (1 << ADDR_W)) begin : g_bad_size
    $error("ADDR_W too small for MEM_BYTES");
  end
  owner_e            owner_q, owner_d;
  logic [7:0]        starve_q, starve_d;
  logic              zero_q, zero_d;
  logic [31:0]       cpu_rdata_q, dbg_rdata_q, cpu_rdata, dbg_rdata, ret_data;
  logic              cpu_win, dbg_win, win, win_we, oob, cpu_rvalid, dbg_rvalid;
  logic [ADDR_W-1:0] win_addr, mem_addr;
  logic [31:0]       win_wdata;
  logic [3:0]        win_wstrb;
  always_comb begin
    dbg_win   = !rst && bus.dbg_req && (!bus.cpu_req || starve_q == MAX_W);
    cpu_win   = !rst && bus.cpu_req && !dbg_win;
    win       = cpu_win || dbg_win;
    win_we    = dbg_win ? bus.dbg_we    : bus.cpu_we;
    win_addr  = dbg_win ? bus.dbg_addr  : bus.cpu_addr;
    win_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
    win_wstrb = dbg_win ? bus.dbg_wstrb : bus.cpu_wstrb;
    mem_addr  = win_addr & ~ADDR_W'(3);
  end
`ifdef DMEM_ARB_BOUND_CHECK_EN
  assign oob = win && (32'(mem_addr) + 32'd3 >= 32'(MEM_BYTES));
`else
  assign oob = 1'b0;
`endif
  assign bus.mem_en    = win && !oob;
  assign bus.mem_we    = win && win_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = win_wdata;
  assign bus.mem_wstrb = win_we ? win_wstrb : 4'b0;
  assign bus.cpu_gnt   = cpu_win;
  assign bus.dbg_gnt   = dbg_win;
  assign bus.cpu_err   = cpu_win && oob;
  assign bus.dbg_err   = dbg_win && oob;
  // A return cut off by reset is dropped; non-owner rdata keeps its last delivered word.
  always_comb begin
    cpu_rvalid = !rst && owner_q == OWN_CPU;
    dbg_rvalid = !rst && owner_q == OWN_DBG;
    ret_data   = zero_q ? 32'h0 : bus.mem_rdata;
    cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
    dbg_rdata  = dbg_rvalid ? ret_data : dbg_rdata_q;
    starve_d   = (!bus.dbg_req || dbg_win) ? 8'd0 : (starve_q == MAX_W ? starve_q : starve_q + 8'd1);
    owner_d    = (!win || win_we) ? OWN_NONE : (dbg_win ? OWN_DBG : OWN_CPU);
    zero_d     = oob;
  end
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.dbg_rdata  = dbg_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 8'd0;
      owner_q  <= OWN_NONE;
      zero_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      zero_q   <= zero_d;
    end
    cpu_rdata_q <= cpu_rdata;
    dbg_rdata_q <= dbg_rdata;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random stimulus against a byte-level reference model of the arbiter
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT  = 8;
  localparam int MEM_BYTES = 1024;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dmem_port_arbiter_if #(.ADDR_W(12)) bus ();
  dmem_port_arbiter #(.ADDR_W(12), .MAX_WAIT(MAX_WAIT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [7:0] mem_arr [4096];
  logic [7:0] ref_mem [4096];
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= {mem_arr[bus.mem_addr+3], mem_arr[bus.mem_addr+2], mem_arr[bus.mem_addr+1], mem_arr[bus.mem_addr]};
    else
      bus.mem_rdata <= $urandom;
    if (bus.mem_en && bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) mem_arr[bus.mem_addr+12'(b)] <= bus.mem_wdata[8*b+:8];
  end
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  logic        rst_v;
  logic        req_v [2];
  logic        we_v [2];
  logic [11:0] addr_v [2];
  logic [31:0] wd_v [2];
  logic [3:0]  ws_v [2];
  int          starve = 0;
  int          owner = 0;
  logic [31:0] pend = 0;
  logic [31:0] last_rd [2];
  bit          known [2];
  int          last_ew = 0;
  int          dbg_gnts = 0;
  task automatic tick();
    int ew;
    logic oob;
    logic [11:0] a;
    logic [31:0] orv, ord;
    rst = rst_v;
    bus.cpu_req = req_v[0]; bus.cpu_we = we_v[0]; bus.cpu_addr = addr_v[0]; bus.cpu_wdata = wd_v[0]; bus.cpu_wstrb = ws_v[0];
    bus.dbg_req = req_v[1]; bus.dbg_we = we_v[1]; bus.dbg_addr = addr_v[1]; bus.dbg_wdata = wd_v[1]; bus.dbg_wstrb = ws_v[1];
    #4;
    // The debug port wins only when it asks alone or has been denied MAX_WAIT cycles in a row.
    if (rst_v) ew = 0;
    else if (req_v[1] && (!req_v[0] || starve >= MAX_WAIT)) ew = 2;
    else if (req_v[0]) ew = 1;
    else ew = 0;
    a = (ew != 0) ? (addr_v[ew-1] & 12'hFFC) : 12'h0;
`ifdef DMEM_ARB_BOUND_CHECK_EN
    oob = (ew != 0) && (int'(a) + 3 >= MEM_BYTES);
`else
    oob = 1'b0;
`endif
    check("cpu_gnt", 32'(bus.cpu_gnt), 32'(ew == 1));
    check("dbg_gnt", 32'(bus.dbg_gnt), 32'(ew == 2));
    check("mem_en", 32'(bus.mem_en), 32'(ew != 0 && !oob));
    check("cpu_err", 32'(bus.cpu_err), 32'(ew == 1 && oob));
    check("dbg_err", 32'(bus.dbg_err), 32'(ew == 2 && oob));
    if (ew != 0 && !oob) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(a));
      check("mem_we", 32'(bus.mem_we), 32'(we_v[ew-1]));
      check("mem_wstrb", 32'(bus.mem_wstrb), we_v[ew-1] ? 32'(ws_v[ew-1]) : 32'h0);
      if (we_v[ew-1]) check("mem_wdata", bus.mem_wdata, wd_v[ew-1]);
    end
    for (int p = 0; p < 2; p++) begin
      orv = 32'(p == 0 ? bus.cpu_rvalid : bus.dbg_rvalid);
      ord = p == 0 ? bus.cpu_rdata : bus.dbg_rdata;
      check(p == 0 ? "cpu_rvalid" : "dbg_rvalid", orv, 32'(!rst_v && owner == p + 1));
      if (!rst_v && owner == p + 1) begin
        check(p == 0 ? "cpu_rdata" : "dbg_rdata", ord, pend);
        last_rd[p] = pend;
        known[p] = 1'b1;
      end else if (known[p]) begin
        check(p == 0 ? "cpu_rdata_hold" : "dbg_rdata_hold", ord, last_rd[p]);
      end
    end
    if (ew == 2) dbg_gnts++;
    last_ew = ew;
    if (rst_v) begin
      starve = 0;
      owner = 0;
    end else begin
      starve = (req_v[1] && ew != 2) ? ((starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1) : 0;
      owner = (ew != 0 && !we_v[ew-1]) ? ew : 0;
      pend = oob ? 32'h0 : {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      if (ew != 0 && we_v[ew-1] && !oob)
        for (int b = 0; b < 4; b++)
          if (ws_v[ew-1][b]) ref_mem[a+12'(b)] = wd_v[ew-1][8*b+:8];
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int p, input logic r, input logic w, input logic [11:0] ad, input logic [31:0] d, input logic [3:0] s);
    req_v[p] = r; we_v[p] = w; addr_v[p] = ad; wd_v[p] = d; ws_v[p] = s;
  endtask
  task automatic rand_req(input int p);
    logic [11:0] ad;
    ad = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1016, 1023)) : 12'($urandom_range(0, 1023));
    set_req(p, 1'b1, 1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom));
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 8'h0;
      ref_mem[i] = 8'h0;
    end
    rst_v = 1'b1;
    set_req(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
    tick();
    tick();
    rst_v = 1'b0;
    tick();
    check("rst_release_cpu_first", 32'(last_ew), 32'd1);
    set_req(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    set_req(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    check("wr_rd_data", last_rd[0], 32'hDEADBEEF);
    dbg_gnts = 0;
    set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 12'h014, 32'h0, 4'h0);
    for (int i = 0; i < 27; i++) tick();
    check("contention_dbg_grants", 32'(dbg_gnts), 32'd3);
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 12'h000, 32'h11223344, 4'hF);
    tick();
    set_req(1, 1'b1, 1'b1, 12'h004, 32'h55667788, 4'hF);
    tick();
    set_req(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_req(0, 1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 12'h004, 32'h0, 4'h0);
    tick();
    set_req(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    check("interleave_dbg_data", last_rd[1], 32'h55667788);
    check("interleave_cpu_data", last_rd[0], 32'h11223344);
    set_req(1, 1'b1, 1'b1, 12'h021, 32'h0000AB00, 4'b0010);
    tick();
    set_req(1, 1'b1, 1'b0, 12'h021, 32'h0, 4'hF);
    tick();
    set_req(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    check("partial_write_data", last_rd[1], 32'h0000AB00);
    set_req(0, 1'b1, 1'b0, 12'h3FE, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    tick();
    rst_v = 1'b1;
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    tick();
    rst_v = 1'b0;
    tick();
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p] || last_ew == p + 1) begin
          if ($urandom_range(0, 3) != 0) rand_req(p);
          else req_v[p] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[p] = 1'b0;
        end
      end
      rst_v = ($urandom_range(0, 99) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
